shift_register_ctrl: RTL and testbench

//   Frame sequencer for the serial shift_register datapath (DIN/CLK/RST/DOUT, DEPTH flops).

---
 rtl/shift_register_ctrl_pkg.sv | 17 +
 rtl/shift_capture.sv | 43 ++++
 rtl/shift_register_ctrl.sv | 154 +++++++++++++++
 tb/tb_shift_register_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_ctrl_pkg.sv
// Shared types and sizing helpers for the shift_register frame sequencer.
// The bench imports this too, so state encodings stay in one place.
package shift_register_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // RUN counts 0..WIDTH+DEPTH-1; one spare code keeps the counter from wrapping.
   function automatic int cnt_width(input int width, input int depth);
      return $clog2(width + depth + 1);
   endfunction

endpackage

// File: rtl/shift_capture.sv
// WIDTH-bit deserializer: stores bit_i at serial position idx_i while en_i is high,
// and presents the result in word order (serial position 0 is the MSB when MSB_FIRST).
module shift_capture
   import shift_register_ctrl_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int IDX_W     = 3,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] word_o,
   output logic [WIDTH-1:0] word_nxt_o
);

   logic [WIDTH-1:0] seq_q, seq_d;

   always_comb begin
      seq_d = seq_q;
      if (clr_i) begin
         seq_d = '0;
      end else if (en_i) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (idx_i == IDX_W'(i)) seq_d[i] = bit_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) seq_q <= '0;
      else       seq_q <= seq_d;
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_order
      assign word_o[g]     = MSB_FIRST ? seq_q[WIDTH-1-g] : seq_q[g];
      assign word_nxt_o[g] = MSB_FIRST ? seq_d[WIDTH-1-g] : seq_d[g];
   end

endmodule

// File: rtl/shift_register_ctrl.sv
// Frame sequencer for a DEPTH-stage serial shift_register: flushes it, streams one
// parallel word through it, rebuilds the word from DOUT and reports a loopback match.
module shift_register_ctrl
   import shift_register_ctrl_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   // Both sides: a transfer happens on a rising edge where VALID and READY are both high;
   // the offering side holds VALID/DATA until then, READY never depends on VALID.
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_DATA,
   output logic             MATCH,
   output logic             SR_RST,
   output logic             SR_DIN,
   input  logic             SR_DOUT,
   output state_t           DBG_STATE
);

   localparam int CW   = cnt_width(WIDTH, DEPTH);
   localparam int LAST = WIDTH + DEPTH - 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic             in_ready_q, in_ready_d;
   logic             sr_rst_q, sr_rst_d;
   logic             sr_din_q, sr_din_d;
   logic             out_valid_q, out_valid_d;
   logic             match_q, match_d;

   logic [WIDTH-1:0] tx_seq;
   logic             cap_clr, cap_en;
   logic [CW-1:0]    cap_idx;
   logic [WIDTH-1:0] rx_word, rx_word_nxt;

   for (genvar g = 0; g < WIDTH; g++) begin : g_tx_seq
      assign tx_seq[g] = MSB_FIRST ? tx_q[WIDTH-1-g] : tx_q[g];
   end

   // Serial bit driven during RUN step n; steps past the word send zeros.
   function automatic logic din_at(input logic [WIDTH-1:0] seq, input logic [CW-1:0] n);
      din_at = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (n == CW'(i)) din_at = seq[i];
      end
   endfunction

   assign cap_en  = (state_q == ST_RUN) && (cnt_q >= CW'(DEPTH));
   assign cap_idx = cnt_q - CW'(DEPTH);

   shift_capture #(
      .WIDTH     (WIDTH),
      .IDX_W     (CW),
      .MSB_FIRST (MSB_FIRST)
   ) u_capture (
      .clk_i      (CLK),
      .rst_i      (RST),
      .clr_i      (cap_clr),
      .en_i       (cap_en),
      .idx_i      (cap_idx),
      .bit_i      (SR_DOUT),
      .word_o     (rx_word),
      .word_nxt_o (rx_word_nxt)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tx_d        = tx_q;
      in_ready_d  = 1'b0;
      sr_rst_d    = 1'b0;
      sr_din_d    = 1'b0;
      out_valid_d = 1'b0;
      match_d     = 1'b0;
      cap_clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (IN_VALID && in_ready_q) begin
               state_d    = ST_FLUSH;
               tx_d       = IN_DATA;
               in_ready_d = 1'b0;
               sr_rst_d   = 1'b1;
               cap_clr    = 1'b1;
            end
         end
         ST_FLUSH: begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            sr_din_d = din_at(tx_seq, '0);
         end
         ST_RUN: begin
            if (cnt_q == CW'(LAST)) begin
               state_d     = ST_DONE;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               match_d     = (rx_word_nxt == tx_q);
            end else begin
               cnt_d    = cnt_q + CW'(1);
               sr_din_d = din_at(tx_seq, cnt_q + CW'(1));
            end
         end
         ST_DONE: begin
            out_valid_d = 1'b1;
            match_d     = match_q;
            if (OUT_READY) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               match_d     = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tx_q        <= '0;
         in_ready_q  <= 1'b0;
         sr_rst_q    <= 1'b1;
         sr_din_q    <= 1'b0;
         out_valid_q <= 1'b0;
         match_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tx_q        <= tx_d;
         in_ready_q  <= in_ready_d;
         sr_rst_q    <= sr_rst_d;
         sr_din_q    <= sr_din_d;
         out_valid_q <= out_valid_d;
         match_q     <= match_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = rx_word;
   assign MATCH     = match_q;
   assign SR_RST    = sr_rst_q;
   assign SR_DIN    = sr_din_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Directed bench: two sequencers (MSB-first and LSB-first), each looped through
// its own DEPTH-stage shift register with an optional stuck-at-0 on DOUT.
module tb_shift_register_ctrl;
   import shift_register_ctrl_pkg::*;

   localparam int W = 4;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Instance a: MSB first
   logic         a_in_valid = 1'b0, a_out_ready = 1'b0, fault = 1'b0;
   logic [W-1:0] a_in_data = '0, a_out_data;
   logic         a_in_ready, a_out_valid, a_match, a_sr_rst, a_sr_din, a_sr_dout;
   state_t       a_state;
   logic [D-1:0] a_sr;

   // Instance b: LSB first
   logic         b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic [W-1:0] b_in_data = '0, b_out_data;
   logic         b_in_ready, b_out_valid, b_match, b_sr_rst, b_sr_din, b_sr_dout;
   state_t       b_state;
   logic [D-1:0] b_sr;

   shift_register_ctrl #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_dut_a (
      .CLK(clk), .RST(rst),
      .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .IN_DATA(a_in_data),
      .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .OUT_DATA(a_out_data),
      .MATCH(a_match), .SR_RST(a_sr_rst), .SR_DIN(a_sr_din), .SR_DOUT(a_sr_dout),
      .DBG_STATE(a_state)
   );

   shift_register_ctrl #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_dut_b (
      .CLK(clk), .RST(rst),
      .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_DATA(b_in_data),
      .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_DATA(b_out_data),
      .MATCH(b_match), .SR_RST(b_sr_rst), .SR_DIN(b_sr_din), .SR_DOUT(b_sr_dout),
      .DBG_STATE(b_state)
   );

   always_ff @(posedge clk or posedge a_sr_rst) begin
      if (a_sr_rst) a_sr <= '0;
      else          a_sr <= {a_sr[D-2:0], a_sr_din};
   end
   assign a_sr_dout = fault ? 1'b0 : a_sr[D-1];

   always_ff @(posedge clk or posedge b_sr_rst) begin
      if (b_sr_rst) b_sr <= '0;
      else          b_sr <= {b_sr[D-2:0], b_sr_din};
   end
   assign b_sr_dout = b_sr[D-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [W-1:0] d);
      a_in_valid = 1'b1;
      a_in_data  = d;
      tick();
      a_in_valid = 1'b0;
   endtask

   task automatic release_a();
      a_out_ready = 1'b1;
      tick();
      chk("a_release_in_ready", 32'(a_in_ready), 32'd1);
      a_out_ready = 1'b0;
   endtask

   task automatic wait_valid(input bit sel, output int lat);
      lat = 0;
      while (!(sel ? b_out_valid : a_out_valid) && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat;
      int           gap;
      logic [7:0]   exp_din;
      logic [W-1:0] seen;

      // Reset held for two edges
      repeat (2) tick();
      chk("rst_sr_rst",    32'(a_sr_rst),    32'd1);
      chk("rst_in_ready",  32'(a_in_ready),  32'd0);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_data",  32'(a_out_data),  32'd0);
      chk("rst_match",     32'(a_match),     32'd0);
      chk("rst_state",     32'(a_state),     32'(ST_IDLE));
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
      chk("post_rst_sr_rst",   32'(a_sr_rst),   32'd0);

      // Frame 1001: flush pulse, serial pattern, 9-edge latency
      send_a(4'b1001);
      chk("f1_flush_sr_rst",   32'(a_sr_rst),   32'd1);
      chk("f1_flush_in_ready", 32'(a_in_ready), 32'd0);
      chk("f1_flush_state",    32'(a_state),    32'(ST_FLUSH));
      exp_din = 8'b1001_0000;
      for (int n = 0; n < 8; n++) begin
         tick();
         chk("f1_sr_din",    32'(a_sr_din),    32'(exp_din[7]));
         chk("f1_sr_rst",    32'(a_sr_rst),    32'd0);
         chk("f1_out_valid", 32'(a_out_valid), 32'd0);
         exp_din = exp_din << 1;
      end
      tick();
      chk("f1_out_valid_9", 32'(a_out_valid), 32'd1);
      chk("f1_out_data",    32'(a_out_data),  32'(4'b1001));
      chk("f1_match",       32'(a_match),     32'd1);
      release_a();
      chk("f1_out_valid_drop", 32'(a_out_valid), 32'd0);

      // Frame 1011 with a stalled consumer and a stray offer while waiting
      send_a(4'b1011);
      wait_valid(1'b0, lat);
      chk("f2_latency", 32'(lat), 32'd9);
      a_in_valid = 1'b1;
      a_in_data  = 4'b0101;
      repeat (5) begin
         tick();
         chk("f2_hold_valid",    32'(a_out_valid), 32'd1);
         chk("f2_hold_data",     32'(a_out_data),  32'(4'b1011));
         chk("f2_hold_match",    32'(a_match),     32'd1);
         chk("f2_hold_in_ready", 32'(a_in_ready),  32'd0);
      end
      a_in_valid = 1'b0;
      release_a();
      chk("f2_out_valid_drop", 32'(a_out_valid), 32'd0);
      tick();
      chk("f2_stray_ignored", 32'(a_state), 32'(ST_IDLE));

      // Frame 1111 aborted by reset at RUN step 3
      send_a(4'b1111);
      repeat (4) tick();
      chk("f3_pre_state",  32'(a_state),  32'(ST_RUN));
      chk("f3_pre_sr_din", 32'(a_sr_din), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_state",     32'(a_state),     32'(ST_IDLE));
      chk("abort_sr_rst",    32'(a_sr_rst),    32'd1);
      chk("abort_sr_din",    32'(a_sr_din),    32'd0);
      chk("abort_in_ready",  32'(a_in_ready),  32'd0);
      chk("abort_out_valid", 32'(a_out_valid), 32'd0);
      chk("abort_out_data",  32'(a_out_data),  32'd0);
      chk("abort_match",     32'(a_match),     32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("abort_rel_in_ready",  32'(a_in_ready),  32'd1);
      chk("abort_rel_out_valid", 32'(a_out_valid), 32'd0);

      // Frame 0000 after the abort
      send_a(4'b0000);
      wait_valid(1'b0, lat);
      chk("f4_latency",  32'(lat),        32'd9);
      chk("f4_out_data", 32'(a_out_data), 32'(4'b0000));
      chk("f4_match",    32'(a_match),    32'd1);
      release_a();

      // Frame 0110 with DOUT stuck at 0
      fault = 1'b1;
      send_a(4'b0110);
      wait_valid(1'b0, lat);
      chk("f5_latency",  32'(lat),        32'd9);
      chk("f5_out_data", 32'(a_out_data), 32'(4'b0000));
      chk("f5_match",    32'(a_match),    32'd0);
      release_a();
      fault = 1'b0;

      // LSB-first instance: frame 0001
      b_in_valid = 1'b1;
      b_in_data  = 4'b0001;
      tick();
      b_in_valid = 1'b0;
      tick();
      chk("b_first_din", 32'(b_sr_din), 32'd1);
      wait_valid(1'b1, lat);
      chk("b_latency",  32'(lat),        32'd8);
      chk("b_out_data", 32'(b_out_data), 32'(4'b0001));
      chk("b_match",    32'(b_match),    32'd1);
      b_out_ready = 1'b1;
      tick();
      chk("b_release_in_ready", 32'(b_in_ready), 32'd1);

      // Back-to-back with OUT_READY tied high: IN_READY low for 2+W+D cycles
      b_in_valid = 1'b1;
      b_in_data  = 4'b1010;
      repeat (2) begin
         tick();
         gap  = 0;
         seen = '0;
         while (!b_in_ready && gap < 50) begin
            if (b_out_valid) seen = b_out_data;
            gap++;
            tick();
         end
         chk("b2b_gap",  32'(gap),  32'(2 + W + D));
         chk("b2b_data", 32'(seen), 32'(4'b1010));
      end
      b_in_valid = 1'b0;
      tick();
      chk("b_end_state", 32'(b_state), 32'(ST_IDLE));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
